// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_W = 64;
  localparam int PC_W    = 32;

  localparam logic [1:0] PRIV_MACHINE = 2'b11;

  // One buffered fetch response as presented to decode.
  typedef struct packed {
    logic [FETCH_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               fault_fetch;
    logic               fault_page;
  } fetch_bundle_t;

  localparam int BUNDLE_W = $bits(fetch_bundle_t);

  // Request tracker: idle, or one cache read outstanding.
  typedef enum logic [0:0] {
    REQ_IDLE = 1'b0,
    REQ_WAIT = 1'b1
  } req_state_e;

  // Start of the next 64-bit fetch line; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] next_line(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:3] + 29'd1, 3'b000};
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry bundle FIFO with registered storage. Flush wins over push and pop.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  fetch_bundle_t data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          valid_o,
  output fetch_bundle_t data_o,
  output logic [1:0]    count_o
);

  fetch_bundle_t mem_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          do_push;
  logic          do_pop;

  // Qualify handshakes against occupancy and work out the next count.
  always_comb begin
    do_pop  = pop_i & (count_q != 2'd0);
    do_push = push_i & ((count_q != 2'd2) | do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC tracking, single-outstanding icache reads, redirect
// and stale-response discard, fault halt, and a 2-entry skid buffer to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_enable_i,
  input  logic                branch_request_i,
  input  logic [31:0]         branch_pc_i,
  input  logic [1:0]          branch_priv_i,
  output logic                icache_rd_o,
  output logic [31:0]         icache_pc_o,
  output logic [1:0]          icache_priv_o,
  input  logic                icache_accept_i,
  input  logic                icache_valid_i,
  input  logic [FETCH_W-1:0]  icache_inst_i,
  input  logic                icache_error_i,
  input  logic                icache_page_fault_i,
  output logic                fetch_valid_o,
  output logic [FETCH_W-1:0]  fetch_instr_o,
  output logic [31:0]         fetch_pc_o,
  output logic [1:0]          fetch_pred_branch_o,
  output logic                fetch_fault_fetch_o,
  output logic                fetch_fault_page_o,
  input  logic                fetch_accept_i
);

  req_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [1:0]    priv_q, priv_d;
  logic          discard_q, discard_d;
  logic          halt_q, halt_d;

  logic          outstanding;
  logic          pop;
  logic [2:0]    committed;
  logic          issue;
  logic          fire;
  logic          resp;
  logic          drop;
  logic          push;

  logic          fifo_valid;
  logic [1:0]    fifo_count;
  fetch_bundle_t push_bundle;
  fetch_bundle_t head;

  // Issue condition: committed counts buffered plus in-flight responses, so a
  // read only goes out when a FIFO slot is guaranteed for its response.
  always_comb begin
    outstanding = (state_q == REQ_WAIT);
    pop         = fifo_valid & fetch_accept_i;
    committed   = {1'b0, fifo_count} + {2'b00, outstanding} - {2'b00, pop};
    issue       = !rst_i & fetch_enable_i & !halt_q & !branch_request_i &
                  (!outstanding | icache_valid_i) & (committed < 3'd2);
    fire        = issue & icache_accept_i;
    resp        = icache_valid_i & outstanding;
    drop        = resp & (discard_q | branch_request_i);
    push        = resp & !drop;
  end

  // Request FSM next state; a response and a new accept can share a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE: if (fire) state_d = REQ_WAIT;
      REQ_WAIT: begin
        if (fire)                state_d = REQ_WAIT;
        else if (icache_valid_i) state_d = REQ_IDLE;
      end
      default: state_d = REQ_IDLE;
    endcase
  end

  // PC, privilege, discard and halt next state; redirect has top priority.
  always_comb begin
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    priv_d    = priv_q;
    discard_d = discard_q;
    halt_d    = halt_q;

    if (fire) begin
      req_pc_d = pc_q;
      pc_d     = next_line(pc_q);
    end
    if (resp && discard_q) begin
      discard_d = 1'b0;
    end
    if (push && (icache_error_i || icache_page_fault_i)) begin
      halt_d = 1'b1;
    end
    if (branch_request_i) begin
      pc_d   = branch_pc_i;
      priv_d = branch_priv_i;
      halt_d = 1'b0;
      if (outstanding && !icache_valid_i) begin
        discard_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= REQ_IDLE;
      pc_q      <= BOOT_PC;
      req_pc_q  <= '0;
      priv_q    <= PRIV_MACHINE;
      discard_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      priv_q    <= priv_d;
      discard_q <= discard_d;
      halt_q    <= halt_d;
    end
  end

  // Response payload; data is passed through untouched even when faulting.
  always_comb begin
    push_bundle.instr       = icache_inst_i;
    push_bundle.pc          = req_pc_q;
    push_bundle.fault_fetch = icache_error_i;
    push_bundle.fault_page  = icache_page_fault_i;
  end

  fetch_skid_fifo u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_bundle),
    .pop_i   (pop),
    .flush_i (branch_request_i),
    .valid_o (fifo_valid),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign icache_rd_o         = issue;
  assign icache_pc_o         = {pc_q[31:3], 3'b000};
  assign icache_priv_o       = priv_q;
  assign fetch_valid_o       = fifo_valid;
  assign fetch_instr_o       = head.instr;
  assign fetch_pc_o          = head.pc;
  assign fetch_pred_branch_o = 2'b00;
  assign fetch_fault_fetch_o = head.fault_fetch;
  assign fetch_fault_page_o  = head.fault_page;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a simple icache responder whose data is
// {addr+4, addr} for the requested line address.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fetch_enable_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic [1:0]  branch_priv_i;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic        fetch_accept_i;

  int n_cmp = 0;
  int n_bad = 0;

  int          lat       = 1;
  logic        resp_pend;
  logic [31:0] resp_addr;
  int          resp_left;
  logic [31:0] pf_addr   = 32'h0000_2008;
  logic [31:0] err_addr  = 32'h0000_3000;

  fetch_stage #(.BOOT_PC(32'h8000_0000)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .fetch_enable_i      (fetch_enable_i),
    .branch_request_i    (branch_request_i),
    .branch_pc_i         (branch_pc_i),
    .branch_priv_i       (branch_priv_i),
    .icache_rd_o         (icache_rd_o),
    .icache_pc_o         (icache_pc_o),
    .icache_priv_o       (icache_priv_o),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_inst_i       (icache_inst_i),
    .icache_error_i      (icache_error_i),
    .icache_page_fault_i (icache_page_fault_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_pred_branch_o (fetch_pred_branch_o),
    .fetch_fault_fetch_o (fetch_fault_fetch_o),
    .fetch_fault_page_o  (fetch_fault_page_o),
    .fetch_accept_i      (fetch_accept_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // icache model: captures an accepted read at the negedge, answers lat cycles later.
  initial begin
    icache_valid_i      = 1'b0;
    icache_inst_i       = '0;
    icache_error_i      = 1'b0;
    icache_page_fault_i = 1'b0;
    resp_pend           = 1'b0;
    resp_addr           = '0;
    resp_left           = 0;
    forever begin
      @(posedge clk_i);
      #1;
      icache_valid_i      = 1'b0;
      icache_inst_i       = '0;
      icache_error_i      = 1'b0;
      icache_page_fault_i = 1'b0;
      if (resp_pend) begin
        resp_left--;
        if (resp_left == 0) begin
          icache_valid_i      = 1'b1;
          icache_inst_i       = {resp_addr + 32'd4, resp_addr};
          icache_page_fault_i = (resp_addr == pf_addr);
          icache_error_i      = (resp_addr == err_addr);
          resp_pend           = 1'b0;
        end
      end
      @(negedge clk_i);
      if (icache_rd_o && icache_accept_i) begin
        resp_pend = 1'b1;
        resp_addr = icache_pc_o;
        resp_left = lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i            = 1'b1;
    fetch_enable_i   = 1'b1;
    branch_request_i = 1'b0;
    branch_pc_i      = '0;
    branch_priv_i    = '0;
    icache_accept_i  = 1'b1;
    fetch_accept_i   = 1'b1;

    // Reset
    repeat (3) @(posedge clk_i);
    smp();
    chk("rst_valid", 64'(fetch_valid_o), 64'd0);
    chk("rst_instr", fetch_instr_o, 64'd0);
    chk("rst_pc",    64'(fetch_pc_o), 64'd0);
    chk("rst_pred",  64'(fetch_pred_branch_o), 64'd0);
    chk("rst_ff",    64'(fetch_fault_fetch_o), 64'd0);
    chk("rst_fp",    64'(fetch_fault_page_o), 64'd0);
    chk("rst_rd",    64'(icache_rd_o), 64'd0);

    // R: first cycle out of reset
    adv(); rst_i = 1'b0; smp();
    chk("boot_rd",   64'(icache_rd_o), 64'd1);
    chk("boot_pc",   64'(icache_pc_o), 64'h8000_0000);
    chk("boot_priv", 64'(icache_priv_o), 64'd3);

    // Streaming, k=1
    adv(); smp();
    chk("r1_pc",    64'(icache_pc_o), 64'h8000_0008);
    chk("r1_valid", 64'(fetch_valid_o), 64'd0);
    adv(); smp();
    chk("s0_valid", 64'(fetch_valid_o), 64'd1);
    chk("s0_pc",    64'(fetch_pc_o), 64'h8000_0000);
    chk("s0_instr", fetch_instr_o, 64'h8000_0004_8000_0000);
    adv(); smp();
    chk("s1_pc",    64'(fetch_pc_o), 64'h8000_0008);
    chk("s1_instr", fetch_instr_o, 64'h8000_000C_8000_0008);
    adv(); smp();
    chk("s2_valid", 64'(fetch_valid_o), 64'd1);
    chk("s2_pc",    64'(fetch_pc_o), 64'h8000_0010);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      adv(); fetch_accept_i = 1'b0; smp();
      chk("bp_rd",    64'(icache_rd_o), 64'd0);
      chk("bp_valid", 64'(fetch_valid_o), 64'd1);
      chk("bp_pc",    64'(fetch_pc_o), 64'h8000_0018);
      chk("bp_instr", fetch_instr_o, 64'h8000_001C_8000_0018);
    end
    adv(); fetch_accept_i = 1'b1; smp();
    chk("rel0_pc",   64'(fetch_pc_o), 64'h8000_0018);
    chk("rel0_rd",   64'(icache_rd_o), 64'd1);
    chk("rel0_ipc",  64'(icache_pc_o), 64'h8000_0028);
    adv(); smp();
    chk("rel1_pc",   64'(fetch_pc_o), 64'h8000_0020);
    adv(); smp();
    chk("rel2_pc",   64'(fetch_pc_o), 64'h8000_0028);

    // Enable low: in-flight read still completes
    adv(); fetch_enable_i = 1'b0; smp();
    chk("en0_rd",    64'(icache_rd_o), 64'd0);
    chk("en0_pc",    64'(fetch_pc_o), 64'h8000_0030);
    adv(); smp();
    chk("en1_valid", 64'(fetch_valid_o), 64'd1);
    chk("en1_pc",    64'(fetch_pc_o), 64'h8000_0038);
    adv(); smp();
    chk("en2_valid", 64'(fetch_valid_o), 64'd0);

    // Branch with a read outstanding (k=3)
    adv(); lat = 3; fetch_enable_i = 1'b1; smp();
    chk("bo_rd",  64'(icache_rd_o), 64'd1);
    chk("bo_ipc", 64'(icache_pc_o), 64'h8000_0040);
    adv(); branch_request_i = 1'b1; branch_pc_i = 32'h0000_1004; branch_priv_i = 2'b01; smp();
    chk("bo_br_rd", 64'(icache_rd_o), 64'd0);
    adv(); branch_request_i = 1'b0; smp();
    chk("bo_b1_valid", 64'(fetch_valid_o), 64'd0);
    chk("bo_b1_rd",    64'(icache_rd_o), 64'd0);
    chk("bo_b1_ipc",   64'(icache_pc_o), 64'h0000_1000);
    chk("bo_b1_priv",  64'(icache_priv_o), 64'd1);
    adv(); lat = 1; smp();
    chk("bo_ret_rd",    64'(icache_rd_o), 64'd1);
    chk("bo_ret_ipc",   64'(icache_pc_o), 64'h0000_1000);
    chk("bo_ret_valid", 64'(fetch_valid_o), 64'd0);
    adv(); smp();
    chk("bo_drop_valid", 64'(fetch_valid_o), 64'd0);
    chk("bo_next_ipc",   64'(icache_pc_o), 64'h0000_1008);
    adv(); smp();
    chk("bo_b_valid", 64'(fetch_valid_o), 64'd1);
    chk("bo_b_pc",    64'(fetch_pc_o), 64'h0000_1004);
    chk("bo_b_instr", fetch_instr_o, 64'h0000_1004_0000_1000);

    // Branch in the same cycle as a response
    adv(); branch_request_i = 1'b1; branch_pc_i = 32'h0000_2000; branch_priv_i = 2'b11; smp();
    chk("bs_pre_pc", 64'(fetch_pc_o), 64'h0000_1008);
    chk("bs_br_rd",  64'(icache_rd_o), 64'd0);
    adv(); branch_request_i = 1'b0; smp();
    chk("bs_b1_valid", 64'(fetch_valid_o), 64'd0);
    chk("bs_b1_rd",    64'(icache_rd_o), 64'd1);
    chk("bs_b1_ipc",   64'(icache_pc_o), 64'h0000_2000);
    chk("bs_b1_priv",  64'(icache_priv_o), 64'd3);
    adv(); smp();
    chk("bs_b2_valid", 64'(fetch_valid_o), 64'd0);
    chk("bs_b2_ipc",   64'(icache_pc_o), 64'h0000_2008);

    // Page fault halts issue until a branch
    adv(); smp();
    chk("pf0_pc", 64'(fetch_pc_o), 64'h0000_2000);
    chk("pf0_fp", 64'(fetch_fault_page_o), 64'd0);
    adv(); smp();
    chk("pf1_pc",    64'(fetch_pc_o), 64'h0000_2008);
    chk("pf1_fp",    64'(fetch_fault_page_o), 64'd1);
    chk("pf1_ff",    64'(fetch_fault_fetch_o), 64'd0);
    chk("pf1_instr", fetch_instr_o, 64'h0000_200C_0000_2008);
    chk("pf1_rd",    64'(icache_rd_o), 64'd0);
    adv(); smp();
    chk("pf2_pc", 64'(fetch_pc_o), 64'h0000_2010);
    chk("pf2_fp", 64'(fetch_fault_page_o), 64'd0);
    chk("pf2_rd", 64'(icache_rd_o), 64'd0);
    adv(); smp();
    chk("pf3_valid", 64'(fetch_valid_o), 64'd0);
    chk("pf3_rd",    64'(icache_rd_o), 64'd0);
    adv(); branch_request_i = 1'b1; branch_pc_i = 32'h0000_3000; smp();
    chk("pf_br_rd", 64'(icache_rd_o), 64'd0);
    adv(); branch_request_i = 1'b0; smp();
    chk("pf_res_rd",  64'(icache_rd_o), 64'd1);
    chk("pf_res_ipc", 64'(icache_pc_o), 64'h0000_3000);

    // Bus error also halts
    adv(); smp();
    chk("be0_rd", 64'(icache_rd_o), 64'd1);
    adv(); smp();
    chk("be1_pc", 64'(fetch_pc_o), 64'h0000_3000);
    chk("be1_ff", 64'(fetch_fault_fetch_o), 64'd1);
    chk("be1_fp", 64'(fetch_fault_page_o), 64'd0);
    chk("be1_rd", 64'(icache_rd_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
